// File: rtl/sys_apb_master.sv
// APB requester: accepts one CPU-side request at a time, runs the SETUP/ACCESS
// handshake and returns a one-cycle response, aborting stalled transfers after TIMEOUT cycles.
module sys_apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    req_write,
  input  logic [DATA_WIDTH/8-1:0] req_stb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  input  logic                    pready,
  input  logic                    perr
);

  // Sized to hold TIMEOUT itself so the count can never wrap before the abort.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign req_ready = (state == IDLE);

  // True on the ACCESS edge whose stall would bring the count up to TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: every register here uses <= so all branches see pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      paddr     <= '0;
      pdata     <= '0;
      pwrite    <= 1'b0;
      pstb      <= '0;
      tmo_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            paddr   <= req_addr;
            pdata   <= req_wdata;
            pwrite  <= req_write;
            pstb    <= req_write ? req_stb : '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            tmo_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing on the same edge.
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= perr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (tmo_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
